// File: rtl/dm_arbiter.sv
// Arbiter for the single data-memory port shared by ports A and B, with alignment/range checking.
// Legal access acks 2 cycles after req is sampled, rejected access after 1; the losing port waits with req held.
module dm_arbiter #(
    parameter int MEM_BYTES = 4096,
    parameter bit RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        dm_cs,
    output logic        dm_wr,
    output logic        dm_rd,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic        gnt_b_q, gnt_b_d;
    logic        last_b_q, last_b_d;
    logic        op_wr_q, op_wr_d;
    logic        err_q, err_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_din_q, dm_din_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic        pick_b;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        illegal;

    always_comb begin
        state_d   = state_q;
        gnt_b_d   = gnt_b_q;
        last_b_d  = last_b_q;
        op_wr_d   = op_wr_q;
        err_d     = err_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        illegal   = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // On a tie the port that did not win last time goes next.
                    if (a_req && b_req) begin
                        pick_b = RR_EN ? ~last_b_q : 1'b0;
                    end else begin
                        pick_b = b_req;
                    end
                    sel_wr    = pick_b ? b_wr    : a_wr;
                    sel_addr  = pick_b ? b_addr  : a_addr;
                    sel_wdata = pick_b ? b_wdata : a_wdata;
                    illegal   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);

                    gnt_b_d   = pick_b;
                    last_b_d  = pick_b;
                    op_wr_d   = sel_wr;
                    dm_addr_d = sel_addr;
                    dm_din_d  = sel_wdata;
                    err_d     = illegal;
                    state_d   = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!op_wr_q) begin
                    if (gnt_b_q) begin
                        b_rdata_d = dm_dout;
                    end else begin
                        a_rdata_d = dm_dout;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            dm_addr_q <= 32'h0;
            dm_din_q  <= 32'h0;
            a_rdata_q <= 32'h0;
            b_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            gnt_b_q   <= gnt_b_d;
            last_b_q  <= last_b_d;
            op_wr_q   <= op_wr_d;
            err_q     <= err_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes and acks come straight from state so reset kills them without waiting for an edge.
    assign dm_cs   = (state_q == ACCESS);
    assign dm_wr   = dm_cs & op_wr_q;
    assign dm_rd   = dm_cs & ~op_wr_q;
    assign dm_addr = dm_addr_q;
    assign dm_din  = dm_din_q;

    assign a_ack   = (state_q == RESP) & ~gnt_b_q;
    assign b_ack   = (state_q == RESP) &  gnt_b_q;
    assign a_err   = a_ack & err_q;
    assign b_err   = b_ack & err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: big-endian memory model, ack scoreboard, vector table and directed corner sequences.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_wr = 1'b0;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
    logic        b_req = 1'b0, b_wr = 1'b0;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        dm_cs, dm_wr, dm_rd;
    logic [31:0] dm_addr, dm_din, dm_dout;

    logic        fa_req = 1'b0, fb_req = 1'b0;
    logic        fa_ack, fa_err, fb_ack, fb_err;
    logic [31:0] fa_rdata, fb_rdata;
    logic        f_cs, f_wr, f_rd;
    logic [31:0] f_addr, f_din;

    dm_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    dm_arbiter #(.MEM_BYTES(4096), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .a_req(fa_req), .a_wr(1'b0), .a_addr(32'h0), .a_wdata(32'h0),
        .a_ack(fa_ack), .a_err(fa_err), .a_rdata(fa_rdata),
        .b_req(fb_req), .b_wr(1'b0), .b_addr(32'h4), .b_wdata(32'h0),
        .b_ack(fb_ack), .b_err(fb_err), .b_rdata(fb_rdata),
        .dm_cs(f_cs), .dm_wr(f_wr), .dm_rd(f_rd),
        .dm_addr(f_addr), .dm_din(f_din), .dm_dout(32'h0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Big-endian byte-addressed memory; undriven read data modelled as zero.
    logic [7:0]  mem [0:4095];
    logic [11:0] ma;
    assign ma = dm_addr[11:0];
    assign dm_dout = dm_cs ? {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]} : 32'h0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        mem[12'h030] <= 8'h0A; mem[12'h031] <= 8'h0B; mem[12'h032] <= 8'h0C; mem[12'h033] <= 8'h0D;
        mem[12'h040] <= 8'h11; mem[12'h041] <= 8'h22; mem[12'h042] <= 8'h33; mem[12'h043] <= 8'h44;
    end

    always @(posedge clk) begin
        if (dm_cs && dm_wr) begin
            mem[ma]          <= dm_din[31:24];
            mem[ma + 12'd1]  <= dm_din[23:16];
            mem[ma + 12'd2]  <= dm_din[15:8];
            mem[ma + 12'd3]  <= dm_din[7:0];
        end
    end

    function automatic logic [31:0] memword(input logic [11:0] a);
        return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port_b;
        logic        err;
        logic [31:0] rdata;
        int          at;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_ack(input logic pb, input logic err, input logic [31:0] rdata, input int at);
        exp_t e;
        e.port_b = pb; e.err = err; e.rdata = rdata; e.at = at;
        exp_q.push_back(e);
    endtask

    int wr_cnt = 0, rd_cnt = 0, cs_cnt = 0;
    logic overlap = 1'b0;

    always @(negedge clk) begin
        if (dm_wr) wr_cnt++;
        if (dm_rd) rd_cnt++;
        if (dm_cs) cs_cnt++;
        if (dm_wr && dm_rd) overlap = 1'b1;
        if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'h0, a_ack, b_ack}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_port_b", {31'h0, b_ack}, {31'h0, e.port_b});
                check("ack_cycle", 32'(cyc), 32'(e.at));
                check("ack_err", {31'h0, e.port_b ? b_err : a_err}, {31'h0, e.err});
                check("ack_rdata", e.port_b ? b_rdata : a_rdata, e.rdata);
            end
        end
    end

    // Caller is at a negedge; req goes up now and drops at the negedge where ack is seen.
    task automatic run_port(input logic pb, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit seen = 1'b0;
        if (pb) begin
            b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pb ? b_ack : a_ack) seen = 1'b1;
        end
        if (!seen) check(pb ? "b_ack_timeout" : "a_ack_timeout", 32'h0, 32'h1);
        if (pb) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {25'h0, dm_cs, dm_wr, dm_rd, a_ack, b_ack, a_err, b_err}, 32'h0);
        check({tag, "_dm_addr"}, dm_addr, 32'h0);
        check({tag, "_dm_din"},  dm_din,  32'h0);
        check({tag, "_a_rdata"}, a_rdata, 32'h0);
        check({tag, "_b_rdata"}, b_rdata, 32'h0);
    endtask

    typedef struct {
        logic        pb;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int e0, snap, fa_n, fb_n;

        vecs[0] = '{1'b0, 1'b1, 32'h010,  32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1] = '{1'b0, 1'b0, 32'h010,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h002,  32'h11111111, 1'b1, 32'h00000000};
        vecs[3] = '{1'b1, 1'b1, 32'hFFC,  32'h55AA55AA, 1'b0, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 32'h1000, 32'h99999999, 1'b1, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'h55AA55AA};
        vecs[6] = '{1'b0, 1'b0, 32'h030,  32'h0,        1'b0, 32'h0A0B0C0D};
        vecs[7] = '{1'b0, 1'b0, 32'h013,  32'h0,        1'b1, 32'h0A0B0C0D};
        vecs[8] = '{1'b1, 1'b0, 32'h030,  32'h0,        1'b0, 32'h0A0B0C0D};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: one access at a time, legal acks in cycle 2, rejected in cycle 1.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            e0 = cyc;
            expect_ack(vecs[v].pb, vecs[v].err, vecs[v].rdata, e0 + (vecs[v].err ? 1 : 2));
            run_port(vecs[v].pb, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
        end
        @(negedge clk);
        check("tbl_wr_pulses", 32'(wr_cnt), 32'd2);
        check("tbl_cs_cycles", 32'(cs_cnt), 32'd6);
        check("mem_0x10", memword(12'h010), 32'hDEADBEEF);
        check("mem_0x00_untouched", memword(12'h000), 32'h00000000);
        check("mem_0xFFC", memword(12'hFFC), 32'h55AA55AA);

        // Simultaneous requests after a B grant: A first, B three cycles later.
        e0 = cyc;
        expect_ack(1'b0, 1'b0, 32'h00000000, e0 + 2);
        expect_ack(1'b1, 1'b0, 32'h0A0B0C0D, e0 + 5);
        fork
            run_port(1'b0, 1'b0, 32'h020, 32'h0);
            run_port(1'b1, 1'b1, 32'h024, 32'h12345678);
        join
        @(negedge clk);
        check("mem_0x24", memword(12'h024), 32'h12345678);

        // Both ports saturating with round-robin: strict A/B alternation.
        @(negedge clk);
        e0 = cyc;
        for (int k = 0; k < 8; k++) begin
            expect_ack(k[0], 1'b0, k[0] ? 32'h12345678 : 32'h00000000, e0 + 2 + 3 * k);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) run_port(1'b0, 1'b1, 32'(32'h100 + 4 * k), 32'(k + 1));
            end
            begin
                for (int k = 0; k < 4; k++) run_port(1'b1, 1'b0, 32'h024, 32'h0);
            end
        join
        @(negedge clk);
        check("mem_0x10C", memword(12'h10C), 32'h00000004);

        // Fixed priority with both held high: only A is ever served.
        @(negedge clk);
        fa_req = 1'b1; fb_req = 1'b1;
        fa_n = 0; fb_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fa_ack) fa_n++;
            if (fb_ack) fb_n++;
        end
        fa_req = 1'b0; fb_req = 1'b0;
        check("fp_a_acks", 32'(fa_n), 32'd10);
        check("fp_b_acks", 32'(fb_n), 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Reset during a store's ACCESS cycle: no write, no ack.
        snap = wr_cnt;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h040; a_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("t5_in_access", {30'h0, dm_cs, dm_wr}, 32'h3);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("t5_midreset");
        a_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_write", 32'(wr_cnt - snap), 32'd0);
        check("t5_mem_0x40", memword(12'h040), 32'h11223344);
        e0 = cyc;
        expect_ack(1'b0, 1'b0, 32'h11223344, e0 + 2);
        expect_ack(1'b1, 1'b0, 32'h0A0B0C0D, e0 + 5);
        fork
            run_port(1'b0, 1'b0, 32'h040, 32'h0);
            run_port(1'b1, 1'b0, 32'h030, 32'h0);
        join

        // Single load: one dm_rd cycle; a later B access leaves a_rdata alone.
        @(negedge clk);
        snap = rd_cnt;
        e0 = cyc;
        expect_ack(1'b0, 1'b0, 32'h0A0B0C0D, e0 + 2);
        run_port(1'b0, 1'b0, 32'h030, 32'h0);
        @(negedge clk);
        check("t6_rd_cycles", 32'(rd_cnt - snap), 32'd1);
        e0 = cyc;
        expect_ack(1'b1, 1'b0, 32'h0A0B0C0D, e0 + 2);
        run_port(1'b1, 1'b1, 32'h050, 32'h77777777);
        @(negedge clk);
        check("t6_a_rdata_held", a_rdata, 32'h0A0B0C0D);
        check("t6_mem_0x50", memword(12'h050), 32'h77777777);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("wr_rd_overlap", {31'h0, overlap}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
